// File: rtl/ili9341_spi_arbiter.sv
// ili9341_spi_arbiter
//   Byte-level SPI sequencer and two-port arbiter for the ILI9341 link.
//   Port 0 (panel initialiser) and port 1 (display/pattern unit) offer
//   command/data bytes. One requester is granted per burst, and its bytes
//   are serialised MSB-first in SPI mode 0 (SCK idles low; MOSI changes on
//   the edge that starts a low phase, so the panel samples on SCK rising).
//   The grant is held until the burst ends.
//
// Parameters
//   CLK_DIV   clk cycles per SCK half-period (>=1)
//   IDLE_GAP  clk cycles CS is held high in GAP between bursts (>=1)
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   reqN/dcN/dataN/lastN  byte offer from port N (held until ackN)
//   ackN                  1-cycle pulse when the offered byte is latched
//   busy                  CS low or inter-burst gap in progress
//   owner                 current / most recent grantee
//   tft_cs/dc/clk/din     SPI lines to the panel
//
// Build option
//   ILI9341_ARB_RR_EN  defined: round-robin on a tie (the non-owner wins)
//                      undefined: fixed priority, port 0 wins a tie
module ili9341_spi_arbiter #(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       dc0,
  input  logic       dc1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       owner,
  output logic       tft_cs,
  output logic       tft_dc,
  output logic       tft_clk,
  output logic       tft_din
);

  localparam int DW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    data_q;
  logic          last_q;

  logic       any_req, win, sel;
  logic       sel_req, sel_dc, sel_last;
  logic [7:0] sel_data;

  // In IDLE the mux follows the arbitration winner; during a burst it is
  // locked to the owner so the other port is ignored.
  always_comb begin
    any_req = req0 | req1;
`ifdef ILI9341_ARB_RR_EN
    win = (req0 & req1) ? ~owner : req1;
`else
    win = ~req0;
`endif
    sel      = (state == IDLE) ? win : owner;
    sel_req  = sel ? req1  : req0;
    sel_dc   = sel ? dc1   : dc0;
    sel_data = sel ? data1 : data0;
    sel_last = sel ? last1 : last0;
  end

  // The LOAD cycle doubles as the first low cycle of bit 7, which is why a
  // burst of N bytes keeps CS low for exactly 16*CLK_DIV*N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
      owner   <= 1'b0;
      tft_cs  <= 1'b1;
      tft_dc  <= 1'b0;
      tft_clk <= 1'b0;
      tft_din <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= win;
            data_q  <= sel_data;
            last_q  <= sel_last;
            tft_dc  <= sel_dc;
            tft_din <= sel_data[7];
            tft_cs  <= 1'b0;
            tft_clk <= 1'b0;
            ack0    <= ~win;
            ack1    <= win;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= 3'd7;
            state   <= LOAD;
          end
        end

        LOAD, SHIFT: begin
          state <= SHIFT;
          if (div_cnt != DIV_MAX) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!tft_clk) begin
              tft_clk <= 1'b1;
            end else if (bit_cnt != 3'd0) begin
              tft_clk <= 1'b0;
              bit_cnt <= bit_cnt - 3'd1;
              tft_din <= data_q[bit_cnt - 3'd1];
            end else if (!last_q && sel_req) begin
              // back-to-back byte: reload without leaving SHIFT, CS stays low
              tft_clk <= 1'b0;
              bit_cnt <= 3'd7;
              data_q  <= sel_data;
              last_q  <= sel_last;
              tft_dc  <= sel_dc;
              tft_din <= sel_data[7];
              ack0    <= ~owner;
              ack1    <= owner;
            end else begin
              // burst end, or the owner withdrew its request
              tft_clk <= 1'b0;
              tft_cs  <= 1'b1;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_MAX) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
